// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - multiplexed 7-seg scan controller with blanking, PWM dimming and double-buffered frames
module seg_scan_scheduler #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 160000,
  parameter int BLANK      = 16,
  parameter int CBITS      = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [7*NUM_DIGITS-1:0] frame_data,
  input  logic [3:0]              brightness,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = 7 * NUM_DIGITS;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CBITS-1:0]    cnt_q, cnt_d;
  // parked: FSM is held at the frame origin until the next enabled edge
  logic                parked_q, parked_d;
  logic [FW-1:0]       front_q, front_d;
  logic [FW-1:0]       pending_q, pending_d;
  logic                full_q, full_d;
  logic                ready_q, ready_d;
  logic [6:0]          seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic                fs_q, fs_d;
  logic                boundary;
  logic                xfer;
  logic [6:0]          sel_pattern;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      parked_q  <= 1'b1;
      front_q   <= '0;
      pending_q <= '0;
      full_q    <= 1'b0;
      ready_q   <= 1'b0;
      seg_q     <= '0;
      den_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      parked_q  <= parked_d;
      front_q   <= front_d;
      pending_q <= pending_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
      seg_q     <= seg_d;
      den_q     <= den_d;
      fs_q      <= fs_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    parked_d    = parked_q;
    boundary    = 1'b0;
    fs_d        = 1'b0;
    front_d     = front_q;
    pending_d   = pending_q;
    full_d      = full_q;
    seg_d       = '0;
    den_d       = '0;
    sel_pattern = '0;
    xfer        = frame_valid & ready_q;

    if (!enable) begin
      state_d  = ST_BLANK;
      idx_d    = '0;
      cnt_d    = '0;
      parked_d = 1'b1;
      boundary = 1'b1;
    end else if (parked_q) begin
      state_d  = ST_BLANK;
      idx_d    = '0;
      cnt_d    = '0;
      parked_d = 1'b0;
      boundary = 1'b1;
      fs_d     = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == CBITS'(BLANK - 1)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CBITS'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CBITS'(DWELL - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
              idx_d    = '0;
              boundary = 1'b1;
              fs_d     = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CBITS'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // commit sees the pre-edge pending, so a same-edge transfer waits a frame
    if (boundary && full_q) begin
      front_d = pending_q;
      full_d  = 1'b0;
    end
    if (xfer) begin
      pending_d = frame_data;
      full_d    = 1'b1;
    end
    ready_d = !full_d;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) sel_pattern = front_q[7*i +: 7];
    end

    // outputs are registered from the next-state values so they line up with state
    if (enable && state_d == ST_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        den_d[i] = (idx_d == IW'(i));
      end
      if (brightness == 4'hF || cnt_d[3:0] < brightness) seg_d = sel_pattern;
    end
  end

  assign segment     = seg_q;
  assign digit_en    = den_q;
  assign frame_start = fs_q;
  assign frame_ready = ready_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - randomized bench for seg_scan_scheduler against a frame-position model
module tb_seg_scan_scheduler;

  localparam int ND     = 4;
  localparam int DW     = 32;
  localparam int BL     = 4;
  localparam int SLOT   = BL + DW;
  localparam int PERIOD = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          frame_valid;
  logic          frame_ready;
  logic [7*ND-1:0] frame_data;
  logic [3:0]    brightness;
  logic [6:0]    segment;
  logic [ND-1:0] digit_en;
  logic          frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_pos;
  bit          m_parked;
  logic [27:0] m_front, m_pend;
  bit          m_full, m_ready;
  logic [6:0]  e_seg;
  logic [3:0]  e_den;
  bit          e_fs;

  seg_scan_scheduler #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(BL), .CBITS(6)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .brightness(brightness),
    .segment(segment), .digit_en(digit_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Display position is tracked as an offset within the frame period.
  task automatic model_edge();
    bit xfer, bnd;
    int off, d, c;
    if (rst) begin
      m_pos = 0; m_parked = 1; m_front = '0; m_pend = '0;
      m_full = 0; m_ready = 0; e_seg = '0; e_den = '0; e_fs = 0;
      return;
    end
    xfer = frame_valid && m_ready;
    if (!enable) begin
      bnd = 1; m_parked = 1; m_pos = 0; e_fs = 0;
    end else if (m_parked) begin
      bnd = 1; m_parked = 0; m_pos = 0; e_fs = 1;
    end else begin
      m_pos = (m_pos + 1) % PERIOD;
      bnd = (m_pos == 0);
      e_fs = bnd;
    end
    if (bnd && m_full) begin
      m_front = m_pend;
      m_full = 0;
    end
    if (xfer) begin
      m_pend = frame_data;
      m_full = 1;
    end
    m_ready = !m_full;
    e_seg = '0;
    e_den = '0;
    if (enable) begin
      off = m_pos % SLOT;
      d   = m_pos / SLOT;
      if (off >= BL) begin
        c = off - BL;
        e_den = 4'(1 << d);
        if (brightness == 15 || (c % 16) < brightness)
          e_seg = 7'((m_front >> (7 * d)) & 28'h7f);
      end
    end
  endtask

  task automatic step(input string phase);
    @(posedge clk);
    model_edge();
    #1;
    check({phase, ".segment"}, 32'(segment), 32'(e_seg));
    check({phase, ".digit_en"}, 32'(digit_en), 32'(e_den));
    check({phase, ".frame_start"}, 32'(frame_start), 32'(e_fs));
    check({phase, ".frame_ready"}, 32'(frame_ready), 32'(m_ready));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_valid = 1'b0;
    frame_data = '0; brightness = 4'hF;

    for (int i = 0; i < 3; i++) step("reset");
    rst = 1'b0;
    step("post_reset");

    // first frame, full brightness, two whole frames plus margin
    enable = 1'b1;
    frame_valid = 1'b1;
    frame_data = 28'h0FF_F00F;
    step("load");
    frame_valid = 1'b0;
    for (int i = 0; i < 2 * PERIOD + 10; i++) step("full_on");

    // mid-frame update with a stalled second source
    for (int i = 0; i < 60; i++) step("to_digit1");
    frame_valid = 1'b1; frame_data = 28'h1234567;
    step("xfer_mid");
    frame_data = 28'h7654321;
    for (int i = 0; i < PERIOD + 20; i++) step("stalled");
    frame_valid = 1'b0;

    brightness = 4'd4;
    for (int i = 0; i < PERIOD; i++) step("dim4");
    brightness = 4'd0;
    for (int i = 0; i < PERIOD; i++) step("dark");
    brightness = 4'hF;

    // reset while a frame is pending during digit 2
    for (int i = 0; i < PERIOD; i++) begin
      step("seek");
      if (m_pos == 2 * SLOT + BL + 5) break;
    end
    frame_valid = 1'b1; frame_data = 28'hABCDEF1;
    step("pend_fill");
    frame_valid = 1'b1; frame_data = 28'h5555555;
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0; frame_valid = 1'b0;
    for (int i = 0; i < PERIOD; i++) step("after_rst");

    // enable drop mid-drive and re-enable
    frame_valid = 1'b1; frame_data = 28'h3C3C3C3;
    step("reload");
    frame_valid = 1'b0;
    for (int i = 0; i < 50; i++) step("pre_drop");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step("disabled");
    enable = 1'b1;
    for (int i = 0; i < PERIOD; i++) step("reenabled");

    for (int i = 0; i < 9000; i++) begin
      rst = ($urandom_range(0, 1499) == 0);
      if (enable) enable = ($urandom_range(0, 299) != 0);
      else        enable = ($urandom_range(0, 3) == 0);
      frame_valid = ($urandom_range(0, 49) == 0);
      frame_data  = 28'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom_range(0, 15));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
